// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and helpers for the 7-segment scan controller slice.
package seg_pkg;

   localparam logic [7:0]  SEG_OFF    = 8'h00;
   localparam int unsigned DP_BIT     = 0;
   localparam int unsigned MAX_DIGITS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DEAD = 2'd1,
      ST_LIT  = 2'd2
   } scan_state_e;

   // Minimum width of 1 so degenerate counters still get a real register.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   function automatic logic [MAX_DIGITS-1:0] com_all_off(input int unsigned n);
      logic [MAX_DIGITS-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         if (i < n) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle: frame inputs from the time counters, scan outputs to the digit bank.
interface seg_scan_ctrl_if #(
   parameter int unsigned N_DIGITS = 6
);

   logic [4*N_DIGITS-1:0] digits_bcd;
   logic [N_DIGITS-1:0]   dp_mask;
   logic [N_DIGITS-1:0]   blank_mask;
   logic [N_DIGITS-1:0]   blink_mask;
   logic [N_DIGITS-1:0]   seg_com;
   logic [7:0]            seg_data;

   modport master (
      output digits_bcd, dp_mask, blank_mask, blink_mask,
      input  seg_com, seg_data
   );

   modport slave (
      input  digits_bcd, dp_mask, blank_mask, blink_mask,
      output seg_com, seg_data
   );

endinterface

// File: rtl/seg_scan_ctrl_decoder.sv
// Nibble to segment glyph; bit7=a .. bit1=g, bit0=dp (always 0 here), active-high.
module seg_decoder (
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   always_comb begin
      seg = 8'h00;
      unique case (bcd)
         4'h0: seg = 8'hFC;
         4'h1: seg = 8'h60;
         4'h2: seg = 8'hDA;
         4'h3: seg = 8'hF2;
         4'h4: seg = 8'h66;
         4'h5: seg = 8'hB6;
         4'h6: seg = 8'hBE;
         4'h7: seg = 8'hE0;
         4'h8: seg = 8'hFE;
         4'h9: seg = 8'hF6;
         4'hA: seg = 8'hEE;
         4'hB: seg = 8'h3E;
         4'hC: seg = 8'h9C;
         4'hD: seg = 8'h7A;
         4'hE: seg = 8'h9E;
         4'hF: seg = 8'h8E;
         default: seg = 8'h00;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner: frame snapshot, blink, and a dead cycle
// between digits so the previous pattern never ghosts onto the next common.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned SCAN_HZ  = 1000,
   parameter int unsigned BLINK_HZ = 2,
   parameter int unsigned N_DIGITS = 6
) (
   input logic            clk,
   input logic            rst,
   seg_scan_ctrl_if.slave bus
);

   localparam int unsigned SCAN_DIV    = CLK_HZ / SCAN_HZ;
   localparam int unsigned BLINK_TICKS = SCAN_HZ / (2 * BLINK_HZ);
   localparam int unsigned PRE_W       = clog2(SCAN_DIV);
   localparam int unsigned IDX_W       = clog2(N_DIGITS);
   localparam int unsigned BLK_W       = clog2(BLINK_TICKS);
   localparam logic [N_DIGITS-1:0] COM_OFF = N_DIGITS'(com_all_off(N_DIGITS));

   logic [PRE_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
   logic                  blink_phase_q, blink_phase_d;
   logic [4*N_DIGITS-1:0] snap_bcd_q, snap_bcd_d;
   logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
   logic [N_DIGITS-1:0]   snap_blank_q, snap_blank_d;
   logic [N_DIGITS-1:0]   snap_blink_q, snap_blink_d;
   logic [N_DIGITS-1:0]   seg_com_q, seg_com_d;
   logic [7:0]            seg_data_q, seg_data_d;
   scan_state_e           state_q, state_d;

   logic                  tick;
   logic                  idx_last;
   logic [3:0]            nibble;
   logic [7:0]            dec_seg;
   logic [7:0]            pattern;
   logic [N_DIGITS-1:0]   com_lit;

   always_comb begin
      tick     = (presc_q == PRE_W'(SCAN_DIV - 1));
      idx_last = (idx_q == IDX_W'(N_DIGITS - 1));
      presc_d  = tick ? '0 : presc_q + 1'b1;
      idx_d    = idx_q;
      if (tick) idx_d = idx_last ? '0 : idx_q + 1'b1;
   end

   // Snapshot on the tick that moves to digit 0, so one frame shows one coherent time.
   always_comb begin
      snap_bcd_d   = snap_bcd_q;
      snap_dp_d    = snap_dp_q;
      snap_blank_d = snap_blank_q;
      snap_blink_d = snap_blink_q;
      if (tick && idx_last) begin
         snap_bcd_d   = bus.digits_bcd;
         snap_dp_d    = bus.dp_mask;
         snap_blank_d = bus.blank_mask;
         snap_blink_d = bus.blink_mask;
      end
   end

   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (tick) begin
         if (blink_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   seg_decoder u_dec (
      .bcd (nibble),
      .seg (dec_seg)
   );

   always_comb begin
      nibble           = snap_bcd_q[4*idx_q +: 4];
      pattern          = dec_seg;
      pattern[DP_BIT]  = dec_seg[DP_BIT] | snap_dp_q[idx_q];
      if (snap_blank_q[idx_q] || (snap_blink_q[idx_q] && blink_phase_q)) pattern = SEG_OFF;
      com_lit          = COM_OFF;
      com_lit[idx_q]   = 1'b0;
   end

   // Outputs are loaded from the next state; idx and snapshot have already
   // advanced by the time DEAD hands over to LIT.
   always_comb begin
      state_d    = state_q;
      seg_com_d  = COM_OFF;
      seg_data_d = SEG_OFF;
      unique case (state_q)
         ST_IDLE: if (tick) state_d = ST_DEAD;
         ST_DEAD: state_d = ST_LIT;
         ST_LIT:  if (tick) state_d = ST_DEAD;
         default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_LIT) begin
         seg_com_d  = com_lit;
         seg_data_d = pattern;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q       <= '0;
         idx_q         <= IDX_W'(N_DIGITS - 1);
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         snap_bcd_q    <= '0;
         snap_dp_q     <= '0;
         snap_blank_q  <= '0;
         snap_blink_q  <= '0;
         state_q       <= ST_IDLE;
         seg_com_q     <= COM_OFF;
         seg_data_q    <= SEG_OFF;
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         snap_bcd_q    <= snap_bcd_d;
         snap_dp_q     <= snap_dp_d;
         snap_blank_q  <= snap_blank_d;
         snap_blink_q  <= snap_blink_d;
         state_q       <= state_d;
         seg_com_q     <= seg_com_d;
         seg_data_q    <= seg_data_d;
      end
   end

   assign bus.seg_com  = seg_com_q;
   assign bus.seg_data = seg_data_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: frames predicted from glyph letter sets and tick arithmetic.
module tb_seg_scan_ctrl;

   localparam int N = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seg_scan_ctrl_if #(.N_DIGITS(N)) sif ();

   seg_scan_ctrl #(
      .CLK_HZ   (1000),
      .SCAN_HZ  (100),
      .BLINK_HZ (10),
      .N_DIGITS (N)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         digit;
      logic [7:0] data;
      longint     lit_at;
   } exp_t;

   exp_t   sb[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   longint pcount   = 0;
   longint base     = 0;

   always @(posedge clk) pcount <= pcount + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] glyph(input logic [3:0] v);
      string      tbl [16];
      string      s;
      logic [7:0] r;
      int         k;
      tbl = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
              "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
      s = tbl[v];
      r = 8'h00;
      for (int i = 0; i < s.len(); i++) begin
         k = int'(s[i]) - int'("a");
         r[7-k] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [7:0] expect_seg(input logic [3:0] v, input logic dp,
                                             input logic blank, input logic blink,
                                             input logic off_phase);
      if (blank || (blink && off_phase)) return 8'h00;
      return glyph(v) | {7'b0, dp};
   endfunction

   // Called every negedge after inputs settle: if the coming edge is a frame
   // start (tick onto digit 0), predict that whole frame from current inputs.
   task automatic maybe_push();
      longint     r, n;
      logic [3:0] v;
      logic       ph;
      exp_t       e;
      r = pcount - base + 1;
      if (rst || (r % 10) != 0) return;
      if (((r / 10) - 1) % 6 != 0) return;
      for (int j = 0; j < N; j++) begin
         n  = r / 10 - 1 + j;
         ph = (((n + 1) / 5) % 2) == 1;
         v  = sif.digits_bcd[4*j +: 4];
         e.digit  = j;
         e.data   = expect_seg(v, sif.dp_mask[j], sif.blank_mask[j], sif.blink_mask[j], ph);
         e.lit_at = r + 10 * j + 1;
         sb.push_back(e);
      end
   endtask

   task automatic run(input int cycles, input bit random_mode);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (random_mode && $urandom_range(0, 19) == 0) begin
            sif.digits_bcd = 24'($urandom);
            sif.dp_mask    = 6'($urandom);
            sif.blank_mask = 6'($urandom) & 6'($urandom);
            sif.blink_mask = 6'($urandom);
         end
         maybe_push();
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      sb.delete();
      rst  = 1'b0;
      base = pcount;
      maybe_push();
   endtask

   // Monitor: decoupled from stimulus, pops an expectation on every newly lit digit.
   logic [N-1:0] prev_com  = '1;
   logic [7:0]   prev_data = 8'h00;
   int           gap       = 0;
   bit           seen_lit  = 1'b0;

   always @(posedge clk) begin
      logic [N-1:0] com;
      logic [7:0]   data;
      int           dig;
      exp_t         e;
      #2;
      com  = sif.seg_com;
      data = sif.seg_data;
      if (rst) begin
         seen_lit = 1'b0;
         gap      = 0;
         prev_com = '1;
      end else begin
         check("com_one_low", ($countones(~com) <= 1) ? 1 : 0, 1);
         if (com == '1) begin
            check("dark_data", data, 8'h00);
            gap++;
         end else if (com != prev_com) begin
            if (seen_lit) check("dead_gap", gap, 1);
            dig = -1;
            for (int i = 0; i < N; i++) if (!com[i]) dig = i;
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow: digit %0d lit with no expectation at t=%0t", dig, $time);
            end else begin
               e = sb.pop_front();
               check("digit", dig, e.digit);
               check("seg_data", data, e.data);
               check("lit_time", pcount - base, e.lit_at);
            end
            seen_lit = 1'b1;
            gap      = 0;
         end else begin
            check("data_stable", data, prev_data);
         end
         prev_com  = com;
         prev_data = data;
      end
   end

   initial begin
      bit found;
      sif.digits_bcd = 24'h123456;
      sif.dp_mask    = '0;
      sif.blank_mask = '0;
      sif.blink_mask = '0;
      repeat (3) @(negedge clk);
      check("rst_com", sif.seg_com, 6'b111111);
      check("rst_data", sif.seg_data, 8'h00);
      release_reset();
      run(130, 1'b0);

      // Change digits while digit 2 is lit; the running frame must keep old values.
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         if (sif.seg_com == 6'b111011) begin
            sif.digits_bcd = 24'h999999;
            found = 1'b1;
         end
         maybe_push();
      end
      check("wait_digit2", found, 1);
      run(130, 1'b0);

      sif.dp_mask    = 6'b000100;
      sif.blank_mask = 6'b000001;
      run(130, 1'b0);

      sif.dp_mask    = '0;
      sif.blank_mask = '0;
      sif.blink_mask = 6'b000010;
      run(420, 1'b0);

      for (int k = 0; k < 6; k++) run(100, 1'b1);

      // Asynchronous reset mid-scan, then restart from digit 0.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_com", sif.seg_com, 6'b111111);
      check("midrst_data", sif.seg_data, 8'h00);
      repeat (2) @(negedge clk);
      sif.digits_bcd = 24'h123456;
      sif.dp_mask    = '0;
      sif.blank_mask = '0;
      sif.blink_mask = 6'b100001;
      release_reset();
      run(200, 1'b0);
      for (int k = 0; k < 4; k++) run(100, 1'b1);

      found = 1'b0;
      for (int c = 0; c < 120 && !found; c++) begin
         @(negedge clk);
         if (sb.size() == 0) found = 1'b1;
      end
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
